// File: rtl/node_id_allocator_if.sv
// node_id_allocator_if
// Handshake bundle for the node ID allocator. It carries the parsed-edge
// request channel into the allocator and the resolved-edge channel out of it.
//
// Modports:
//   master : the edge source / sink side (line parser feeding requests,
//            graph builder taking resolved edges)
//   slave  : the allocator itself
//
// Signals:
//   in_valid, in_ready          request handshake
//   in_src_str, in_dst_str      source / destination node strings
//   edge_valid, edge_ready      resolved-edge handshake
//   edge_src_idx, edge_dst_idx  dense node indices
//   edge_src_new, edge_dst_new  index was freshly allocated by this edge
interface node_id_allocator_if #(
    parameter int NODE_STR_WIDTH = 15,
    parameter int NODE_IDX_WIDTH = 10
);
    logic                      in_valid;
    logic                      in_ready;
    logic [NODE_STR_WIDTH-1:0] in_src_str;
    logic [NODE_STR_WIDTH-1:0] in_dst_str;
    logic                      edge_valid;
    logic                      edge_ready;
    logic [NODE_IDX_WIDTH-1:0] edge_src_idx;
    logic [NODE_IDX_WIDTH-1:0] edge_dst_idx;
    logic                      edge_src_new;
    logic                      edge_dst_new;

    modport master (
        output in_valid, in_src_str, in_dst_str, edge_ready,
        input  in_ready, edge_valid, edge_src_idx, edge_dst_idx,
               edge_src_new, edge_dst_new
    );

    modport slave (
        input  in_valid, in_src_str, in_dst_str, edge_ready,
        output in_ready, edge_valid, edge_src_idx, edge_dst_idx,
               edge_src_new, edge_dst_new
    );
endinterface

// File: rtl/node_id_allocator.sv
// node_id_allocator
// Resolves the two node strings of a parsed edge into dense node indices.
// Both strings are looked up in parallel on the two ports of the node-string
// LUT DPRAM; a miss allocates the next free index and writes {1, index} back.
// The resolved index pair is then offered to the graph builder.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   bus (slave)          request channel in, resolved-edge channel out
//   lut_src_str/dst_str  DPRAM port A / B address
//   lut_*_wr_en/wr_data  DPRAM write enables and {valid, index} write data
//   lut_*_rd_data        DPRAM registered read data (1-cycle latency)
//   node_count           indices allocated so far (saturates at MAX_NODES)
//   overflow             sticky: an allocation was attempted with no free index
//
// Optional feature (macro NODE_ID_ALLOC_LUT_CLEAR_EN): after reset the LUT
// is swept to zero, two addresses per cycle, before the first request is
// accepted. Without the macro the LUT relies on zero power-up contents and
// keeps its contents across reset.
module node_id_allocator #(
    parameter int NODE_STR_WIDTH = 15,
    parameter int MAX_NODES      = 1024,
    parameter int NODE_IDX_WIDTH = $clog2(MAX_NODES)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    node_id_allocator_if.slave        bus,
    output logic [NODE_STR_WIDTH-1:0] lut_src_str,
    output logic [NODE_STR_WIDTH-1:0] lut_dst_str,
    output logic                      lut_src_wr_en,
    output logic                      lut_dst_wr_en,
    output logic [NODE_IDX_WIDTH:0]   lut_src_wr_data,
    output logic [NODE_IDX_WIDTH:0]   lut_dst_wr_data,
    input  logic [NODE_IDX_WIDTH:0]   lut_src_rd_data,
    input  logic [NODE_IDX_WIDTH:0]   lut_dst_rd_data,
    output logic [NODE_IDX_WIDTH:0]   node_count,
    output logic                      overflow
);

    localparam logic [NODE_IDX_WIDTH:0]   MAX_CNT = (NODE_IDX_WIDTH+1)'(MAX_NODES);
    localparam logic [NODE_IDX_WIDTH-1:0] SAT_IDX = NODE_IDX_WIDTH'(MAX_NODES - 1);
    localparam logic [NODE_IDX_WIDTH:0]   ONE     = (NODE_IDX_WIDTH+1)'(1);

`ifdef NODE_ID_ALLOC_LUT_CLEAR_EN
    typedef enum logic [2:0] {IDLE, LOOKUP, RESOLVE, OUTPUT, CLEAR} state_t;
    localparam state_t RESET_STATE = CLEAR;
`else
    typedef enum logic [1:0] {IDLE, LOOKUP, RESOLVE, OUTPUT} state_t;
    localparam state_t RESET_STATE = IDLE;
`endif

    state_t state, next_state;

    logic [NODE_STR_WIDTH-1:0] src_str_q, dst_str_q;
    logic [NODE_IDX_WIDTH-1:0] edge_src_idx_q, edge_dst_idx_q;
    logic                      edge_src_new_q, edge_dst_new_q;

    logic [NODE_IDX_WIDTH-1:0] src_idx, dst_idx;
    logic                      src_new, dst_new, src_ovf, dst_ovf;
    logic [NODE_IDX_WIDTH:0]   cnt_after_src, cnt_next;
    logic                      accept;

    assign accept           = bus.in_valid && (state == IDLE);
    assign bus.in_ready     = (state == IDLE);
    assign bus.edge_valid   = (state == OUTPUT);
    assign bus.edge_src_idx = edge_src_idx_q;
    assign bus.edge_dst_idx = edge_dst_idx_q;
    assign bus.edge_src_new = edge_src_new_q;
    assign bus.edge_dst_new = edge_dst_new_q;

`ifdef NODE_ID_ALLOC_LUT_CLEAR_EN
    // Sweep counter: each step clears one even (port A) and one odd (port B)
    // address, so the whole LUT is covered in half as many cycles as entries.
    logic [NODE_STR_WIDTH-2:0] clr_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            clr_cnt <= '0;
        else if (state == CLEAR)
            clr_cnt <= clr_cnt + 1'b1;
    end

    assign lut_src_str = (state == CLEAR) ? {clr_cnt, 1'b0} : src_str_q;
    assign lut_dst_str = (state == CLEAR) ? {clr_cnt, 1'b1} : dst_str_q;
`else
    assign lut_src_str = src_str_q;
    assign lut_dst_str = dst_str_q;
`endif

    // Index resolution, meaningful only in RESOLVE when read data is valid.
    // The destination allocates after the source, so its free index is the
    // count including any source allocation. A missing self-loop reuses the
    // source result so the same address is never written twice. When no
    // index is free the node saturates to MAX_NODES-1, gets no write and is
    // not flagged as new.
    always_comb begin
        src_idx       = '0;
        dst_idx       = '0;
        src_new       = 1'b0;
        dst_new       = 1'b0;
        src_ovf       = 1'b0;
        dst_ovf       = 1'b0;
        cnt_after_src = node_count;
        cnt_next      = node_count;

        if (lut_src_rd_data[NODE_IDX_WIDTH]) begin
            src_idx = lut_src_rd_data[NODE_IDX_WIDTH-1:0];
        end else if (node_count < MAX_CNT) begin
            src_idx       = node_count[NODE_IDX_WIDTH-1:0];
            src_new       = 1'b1;
            cnt_after_src = node_count + ONE;
        end else begin
            src_idx = SAT_IDX;
            src_ovf = 1'b1;
        end

        cnt_next = cnt_after_src;

        if (lut_dst_rd_data[NODE_IDX_WIDTH]) begin
            dst_idx = lut_dst_rd_data[NODE_IDX_WIDTH-1:0];
        end else if (dst_str_q == src_str_q) begin
            dst_idx = src_idx;
        end else if (cnt_after_src < MAX_CNT) begin
            dst_idx  = cnt_after_src[NODE_IDX_WIDTH-1:0];
            dst_new  = 1'b1;
            cnt_next = cnt_after_src + ONE;
        end else begin
            dst_idx = SAT_IDX;
            dst_ovf = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= RESET_STATE;
        else
            state <= next_state;
    end

    // Next state and LUT write strobes. Writes are single-cycle pulses in
    // RESOLVE, which commit well before the next request's LOOKUP read.
    always_comb begin
        next_state      = state;
        lut_src_wr_en   = 1'b0;
        lut_dst_wr_en   = 1'b0;
        lut_src_wr_data = {1'b1, src_idx};
        lut_dst_wr_data = {1'b1, dst_idx};
        case (state)
            IDLE:    if (accept) next_state = LOOKUP;
            LOOKUP:  next_state = RESOLVE;
            RESOLVE: begin
                lut_src_wr_en = src_new;
                lut_dst_wr_en = dst_new;
                next_state    = OUTPUT;
            end
            OUTPUT:  if (bus.edge_ready) next_state = IDLE;
`ifdef NODE_ID_ALLOC_LUT_CLEAR_EN
            CLEAR: begin
                lut_src_wr_en   = 1'b1;
                lut_dst_wr_en   = 1'b1;
                lut_src_wr_data = '0;
                lut_dst_wr_data = '0;
                if (&clr_cnt) next_state = IDLE;
            end
`endif
            default: next_state = RESET_STATE;
        endcase
    end

    // Datapath registers: request strings latched on accept, results and
    // allocation bookkeeping loaded once in RESOLVE and held through OUTPUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_str_q      <= '0;
            dst_str_q      <= '0;
            edge_src_idx_q <= '0;
            edge_dst_idx_q <= '0;
            edge_src_new_q <= 1'b0;
            edge_dst_new_q <= 1'b0;
            node_count     <= '0;
            overflow       <= 1'b0;
        end else begin
            if (accept) begin
                src_str_q <= bus.in_src_str;
                dst_str_q <= bus.in_dst_str;
            end
            if (state == RESOLVE) begin
                edge_src_idx_q <= src_idx;
                edge_dst_idx_q <= dst_idx;
                edge_src_new_q <= src_new;
                edge_dst_new_q <= dst_new;
                node_count     <= cnt_next;
                if (src_ovf || dst_ovf)
                    overflow <= 1'b1;
            end
        end
    end

endmodule
